// File: rtl/fetcher.sv
// Per-warp instruction fetch stage with a one-entry last-fetch buffer.
// Registered outputs; a memory request is never abandoned once it has been issued.
package fetcher_pkg;
  typedef enum logic [2:0] {
    WARP_IDLE    = 3'd0,
    WARP_FETCH   = 3'd1,
    WARP_DECODE  = 3'd2,
    WARP_REQUEST = 3'd3,
    WARP_WAIT    = 3'd4,
    WARP_EXECUTE = 3'd5,
    WARP_UPDATE  = 3'd6,
    WARP_DONE    = 3'd7
  } warp_state_t;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_BUSY = 2'd1,
    FETCH_DONE = 2'd2
  } fetch_state_t;
endpackage

module fetcher
  import fetcher_pkg::*;
#(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int INSTR_WIDTH           = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  warp_state_t                      warp_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] pc,
  input  logic                             flush,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [INSTR_WIDTH-1:0]           mem_read_data,
  output logic [1:0]                       fetcher_state,
  output logic [INSTR_WIDTH-1:0]           instruction
);

  fetch_state_t                     state;
  fetch_state_t                     state_nxt;
  logic                             buf_valid;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] buf_pc;
  logic                             is_fetch;
  logic                             hit;
  logic                             fill;

  assign is_fetch = (warp_state == WARP_FETCH);
  assign hit      = buf_valid && (pc == buf_pc);
  assign fill     = (state == FETCH_BUSY) && mem_read_ready;

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH_IDLE;
    else       state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH_IDLE: begin
        if (is_fetch)
          state_nxt = hit ? FETCH_DONE : FETCH_BUSY;
      end
      FETCH_BUSY: begin
        if (mem_read_ready)
          state_nxt = is_fetch ? FETCH_DONE : FETCH_IDLE;
      end
      FETCH_DONE: begin
        if (!is_fetch)
          state_nxt = FETCH_IDLE;
      end
      default: state_nxt = FETCH_IDLE;
    endcase
  end

  // state output to the scheduler
  always_comb begin
    fetcher_state = state;
  end

  // memory request and instruction registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
      instruction      <= '0;
    end else begin
      if ((state == FETCH_IDLE) && is_fetch && !hit) begin
        mem_read_valid   <= 1'b1;
        mem_read_address <= pc;
      end
      if (fill) begin
        mem_read_valid <= 1'b0;
        instruction    <= mem_read_data;
      end
    end
  end

  // last-fetch buffer; a fill overrides a simultaneous flush
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_pc    <= '0;
    end else if (fill) begin
      buf_valid <= 1'b1;
      buf_pc    <= mem_read_address;
    end else if (flush) begin
      buf_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetcher.sv
// Directed table-driven bench for fetcher.
// Each vector: inputs driven before an edge, outputs expected just after it.
module tb_fetcher;
  import fetcher_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  warp_state_t warp_state;
  logic [7:0]  pc;
  logic        flush;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready;
  logic [31:0] mem_read_data;
  logic [1:0]  fetcher_state;
  logic [31:0] instruction;

  int total = 0;
  int passed = 0;

  fetcher dut (
    .clk              (clk),
    .reset            (reset),
    .warp_state       (warp_state),
    .pc               (pc),
    .flush            (flush),
    .mem_read_valid   (mem_read_valid),
    .mem_read_address (mem_read_address),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data),
    .fetcher_state    (fetcher_state),
    .instruction      (instruction)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    warp_state_t ws;
    logic [7:0]  pc;
    logic        fl;
    logic        rdy;
    logic [31:0] data;
    logic [1:0]  st;
    logic        v;
    logic [7:0]  a;
    logic [31:0] i;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input warp_state_t ws,
                     input logic [7:0] p, input logic fl,
                     input logic rdy, input logic [31:0] d,
                     input logic [1:0] st, input logic v,
                     input logic [7:0] a, input logic [31:0] i);
    vec_t x;
    x.rst = rst; x.ws = ws; x.pc = p; x.fl = fl;
    x.rdy = rdy; x.data = d;
    x.st = st; x.v = v; x.a = a; x.i = i;
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  localparam warp_state_t F = WARP_FETCH;
  localparam warp_state_t D = WARP_DECODE;
  localparam warp_state_t I = WARP_IDLE;

  initial begin
    reset = 1'b1; warp_state = WARP_IDLE; pc = '0; flush = 1'b0;
    mem_read_ready = 1'b0; mem_read_data = '0;

    // reset
    add(1, I, 8'h00, 0, 0, 32'h0,        2'd0, 0, 8'h00, 32'h0);
    // miss at 0x05 with 3 wait cycles
    add(0, F, 8'h05, 0, 0, 32'h0,        2'd1, 1, 8'h05, 32'h0);
    add(0, F, 8'h05, 0, 0, 32'h0,        2'd1, 1, 8'h05, 32'h0);
    add(0, F, 8'h05, 0, 0, 32'h0,        2'd1, 1, 8'h05, 32'h0);
    add(0, F, 8'h05, 0, 0, 32'h0,        2'd1, 1, 8'h05, 32'h0);
    add(0, F, 8'h05, 0, 1, 32'hA0001234, 2'd2, 0, 8'h05, 32'hA0001234);
    add(0, D, 8'h05, 0, 0, 32'h0,        2'd0, 0, 8'h05, 32'hA0001234);
    // hit at 0x05, then flush and refetch misses
    add(0, F, 8'h05, 0, 0, 32'h0,        2'd2, 0, 8'h05, 32'hA0001234);
    add(0, D, 8'h05, 0, 0, 32'h0,        2'd0, 0, 8'h05, 32'hA0001234);
    add(0, I, 8'h05, 1, 0, 32'h0,        2'd0, 0, 8'h05, 32'hA0001234);
    add(0, F, 8'h05, 0, 0, 32'h0,        2'd1, 1, 8'h05, 32'hA0001234);
    add(0, F, 8'h05, 0, 1, 32'hA0001234, 2'd2, 0, 8'h05, 32'hA0001234);
    add(0, D, 8'h05, 0, 0, 32'h0,        2'd0, 0, 8'h05, 32'hA0001234);
    // 0x06 with ready in first cycle
    add(0, F, 8'h06, 0, 0, 32'h0,        2'd1, 1, 8'h06, 32'hA0001234);
    add(0, F, 8'h06, 0, 1, 32'h12345678, 2'd2, 0, 8'h06, 32'h12345678);
    add(0, D, 8'h06, 0, 0, 32'h0,        2'd0, 0, 8'h06, 32'h12345678);
    add(0, I, 8'h06, 0, 0, 32'h0,        2'd0, 0, 8'h06, 32'h12345678);
    // warp leaves FETCH mid-request, request still completes
    add(0, F, 8'h08, 0, 0, 32'h0,        2'd1, 1, 8'h08, 32'h12345678);
    add(0, I, 8'h08, 0, 0, 32'h0,        2'd1, 1, 8'h08, 32'h12345678);
    add(0, I, 8'h08, 0, 0, 32'h0,        2'd1, 1, 8'h08, 32'h12345678);
    add(0, I, 8'h08, 0, 1, 32'h00000001, 2'd0, 0, 8'h08, 32'h00000001);
    add(0, F, 8'h08, 0, 0, 32'h0,        2'd2, 0, 8'h08, 32'h00000001);
    add(0, D, 8'h08, 0, 0, 32'h0,        2'd0, 0, 8'h08, 32'h00000001);
    // stray ready in IDLE is ignored
    add(0, I, 8'h08, 0, 1, 32'hDEADBEEF, 2'd0, 0, 8'h08, 32'h00000001);
    // reset mid-fetch, late ready ignored, refetch misses
    add(0, F, 8'h09, 0, 0, 32'h0,        2'd1, 1, 8'h09, 32'h00000001);
    add(1, F, 8'h09, 0, 0, 32'h0,        2'd0, 0, 8'h00, 32'h0);
    add(0, I, 8'h09, 0, 1, 32'hFFFFFFFF, 2'd0, 0, 8'h00, 32'h0);
    add(0, F, 8'h09, 0, 0, 32'h0,        2'd1, 1, 8'h09, 32'h0);
    add(0, F, 8'h0A, 0, 1, 32'h00000099, 2'd2, 0, 8'h09, 32'h00000099);
    add(0, D, 8'h0A, 0, 0, 32'h0,        2'd0, 0, 8'h09, 32'h00000099);
    // flush coinciding with fill at 0x07: fill wins
    add(0, F, 8'h07, 0, 0, 32'h0,        2'd1, 1, 8'h07, 32'h00000099);
    add(0, F, 8'h07, 1, 1, 32'h00000077, 2'd2, 0, 8'h07, 32'h00000077);
    add(0, D, 8'h07, 0, 0, 32'h0,        2'd0, 0, 8'h07, 32'h00000077);
    add(0, F, 8'h07, 0, 0, 32'h0,        2'd2, 0, 8'h07, 32'h00000077);
    add(0, D, 8'h07, 0, 0, 32'h0,        2'd0, 0, 8'h07, 32'h00000077);
    // flush during a hit check uses pre-flush contents
    add(0, F, 8'h07, 1, 0, 32'h0,        2'd2, 0, 8'h07, 32'h00000077);
    add(0, D, 8'h07, 0, 0, 32'h0,        2'd0, 0, 8'h07, 32'h00000077);
    add(0, F, 8'h07, 0, 0, 32'h0,        2'd1, 1, 8'h07, 32'h00000077);
    add(0, F, 8'h07, 0, 1, 32'h00000078, 2'd2, 0, 8'h07, 32'h00000078);
    add(0, D, 8'h07, 0, 0, 32'h0,        2'd0, 0, 8'h07, 32'h00000078);

    #1;
    for (int k = 0; k < vecs.size(); k++) begin
      reset          = vecs[k].rst;
      warp_state     = vecs[k].ws;
      pc             = vecs[k].pc;
      flush          = vecs[k].fl;
      mem_read_ready = vecs[k].rdy;
      mem_read_data  = vecs[k].data;
      @(posedge clk); #1;
      chk($sformatf("v%0d state", k), 32'(fetcher_state), 32'(vecs[k].st));
      chk($sformatf("v%0d valid", k), 32'(mem_read_valid), 32'(vecs[k].v));
      chk($sformatf("v%0d addr", k), 32'(mem_read_address), 32'(vecs[k].a));
      chk($sformatf("v%0d instr", k), instruction, vecs[k].i);
    end

    // miss latency = 2 + wait cycles, valid high for waits + 1 cycles
    for (int n = 0; n <= 5; n += 5) begin
      automatic int waited = 0;
      automatic int lat = 0;
      automatic int vcnt = 0;
      reset = 1'b0; flush = 1'b0;
      warp_state = WARP_FETCH;
      pc = 8'(8'h20 + n);
      mem_read_ready = 1'b0;
      mem_read_data = 32'hC0DE0000 + 32'(n);
      for (int c = 1; c <= 20; c++) begin
        @(posedge clk); #1;
        if (mem_read_valid) vcnt++;
        if (fetcher_state == 2'd2) begin
          lat = c;
          break;
        end
        mem_read_ready = 1'b0;
        if (fetcher_state == 2'd1) begin
          if (waited == n) mem_read_ready = 1'b1;
          else waited++;
        end
      end
      chk($sformatf("lat w%0d", n), 32'(lat), 32'(2 + n));
      chk($sformatf("vcnt w%0d", n), 32'(vcnt), 32'(n + 1));
      chk($sformatf("instr w%0d", n), instruction,
          32'hC0DE0000 + 32'(n));
      mem_read_ready = 1'b0;
      warp_state = WARP_DECODE;
      @(posedge clk); #1;
      chk($sformatf("idle w%0d", n), 32'(fetcher_state), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
